// File: rtl/reg_file_pkg.sv
// Shared definitions for the banked register file: opcodes, sequencer states,
// and named register indices.
package reg_file_pkg;

  localparam logic [5:0] MOV  = 6'b000100;
  localparam logic [5:0] IMOV = 6'b100100;

  localparam int unsigned X           = 0;
  localparam int unsigned Y           = 1;
  localparam int unsigned ACCUMULATOR = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2
  } ctx_state_e;

  // Port 1 returns its index as an immediate for MOV/IMOV
  function automatic logic is_imm_mode(input logic [5:0] op);
    return (op == MOV) || (op == IMOV);
  endfunction

endpackage

// File: rtl/reg_file_ctx_seq.sv
// Context save/restore sequencer: walks index 0..N-1, one register per cycle,
// in the direction chosen when the request was taken.
module reg_file_ctx_seq
  import reg_file_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          save_req,
  input  logic          restore_req,
  output logic          busy,
  output logic          done,
  output logic          copy_en_c,
  output logic          copy_save_c,
  output logic [AW-1:0] copy_idx_c
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  ctx_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          busy_d, done_d;

  // State, copy index and the busy/done flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next state and index; save takes priority over restore
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (save_req) begin
          state_d = SAVE;
        end else if (restore_req) begin
          state_d = RESTORE;
        end
      end
      SAVE, RESTORE: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = busy_d && (idx_d == LAST_IDX);
  end

  // Per-cycle copy controls for the storage array
  always_comb begin
    copy_en_c   = (state_q != IDLE);
    copy_save_c = (state_q == SAVE);
    copy_idx_c  = idx_q;
  end

endmodule

// File: rtl/reg_file_banked.sv
// Banked general-purpose register file: two combinational read ports, one
// write port, zero/negative flags, and a shadow bank for context switches.
// Optional same-cycle write-to-read bypass: define REG_FILE_BYPASS_EN.
module reg_file_banked
  import reg_file_pkg::*;
#(
  parameter  int unsigned W  = 16,
  parameter  int unsigned N  = 4,
  localparam int unsigned AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          write_enable,
  input  logic [AW-1:0] write_destination,
  input  logic [W-1:0]  write_data,
  input  logic [5:0]    opcode,
  input  logic [AW-1:0] read_sources_1,
  input  logic [AW-1:0] read_sources_2,
  input  logic          save_req,
  input  logic          restore_req,
  output logic [W-1:0]  register_data_1,
  output logic [W-1:0]  register_data_2,
  output logic          flag_zero,
  output logic          flag_neg,
  output logic          busy,
  output logic          done
);

  // One extra bit so the range check stays meaningful when N is a power of two
  localparam int unsigned IW = AW + 1;

  logic [W-1:0]  live_q   [N];
  logic [W-1:0]  shadow_q [N];
  logic          saved_zero_q, saved_neg_q;

  logic          copy_en_c, copy_save_c;
  logic [AW-1:0] copy_idx_c;
  logic          wr_ok_c, rd1_ok_c, rd2_ok_c;

  reg_file_ctx_seq #(.N(N)) u_ctx_seq (
    .clk         (clk),
    .rst         (rst),
    .save_req    (save_req),
    .restore_req (restore_req),
    .busy        (busy),
    .done        (done),
    .copy_en_c   (copy_en_c),
    .copy_save_c (copy_save_c),
    .copy_idx_c  (copy_idx_c)
  );

  // Write acceptance and read index range checks
  always_comb begin
    wr_ok_c  = write_enable && !busy && (IW'(write_destination) < IW'(N));
    rd1_ok_c = (IW'(read_sources_1) < IW'(N));
    rd2_ok_c = (IW'(read_sources_2) < IW'(N));
  end

  // Live/shadow storage, flags, and the per-cycle context copy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live_q       <= '{default: '0};
      shadow_q     <= '{default: '0};
      saved_zero_q <= 1'b0;
      saved_neg_q  <= 1'b0;
      flag_zero    <= 1'b0;
      flag_neg     <= 1'b0;
    end else if (copy_en_c) begin
      if (copy_save_c) begin
        shadow_q[copy_idx_c] <= live_q[copy_idx_c];
        if (done) begin
          saved_zero_q <= flag_zero;
          saved_neg_q  <= flag_neg;
        end
      end else begin
        live_q[copy_idx_c] <= shadow_q[copy_idx_c];
        if (done) begin
          flag_zero <= saved_zero_q;
          flag_neg  <= saved_neg_q;
        end
      end
    end else if (wr_ok_c) begin
      live_q[write_destination] <= write_data;
      flag_zero                 <= (write_data == '0);
      flag_neg                  <= write_data[W-1];
    end
  end

  // Combinational read ports
  always_comb begin
    register_data_1 = '0;
    register_data_2 = '0;
    if (rd1_ok_c) begin
      register_data_1 = live_q[read_sources_1];
    end
    if (rd2_ok_c) begin
      register_data_2 = live_q[read_sources_2];
    end
`ifdef REG_FILE_BYPASS_EN
    if (wr_ok_c && (write_destination == read_sources_1)) begin
      register_data_1 = write_data;
    end
    if (wr_ok_c && (write_destination == read_sources_2)) begin
      register_data_2 = write_data;
    end
`endif
    if (is_imm_mode(opcode)) begin
      register_data_1 = W'(read_sources_1);
    end
  end

endmodule
